// File: rtl/dtc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtc_sched_pkg
// Description : Shared types, widths and helpers for the decision-tree
//               classifier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dtc_sched_pkg;

  // Scheduler transaction phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DTC_W  = 14;  // classifier feature width
  localparam int DTC_OW = 14;  // classifier class-vector width
  localparam int STAT_W = 16;  // per-requester service counter width

  // Width of an index into n requesters (never narrower than one bit)
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dtc_rr_arbiter
// Description : Combinational rotating-priority arbiter. Searches req from
//               index ptr upward, wrapping modulo N, and grants the first
//               asserted bit. The pointer register lives in the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_rr_arbiter
  import dtc_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  // Walk the requesters in priority order starting at ptr; first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtc_shared_sched.sv
`default_nettype none
// ============================================================================
// Module      : dtc_shared_sched
// Description : Round-robin scheduler sharing one combinational decision-tree
//               classifier between N_REQ requesters. Each transaction accepts
//               a feature, holds it on cls_inp for EVAL_CYCLES cycles (a
//               multicycle path through the tree), registers the class vector
//               and returns it tagged with the requester id.
//               Optional macro DTC_SCHED_STATS_EN adds per-requester
//               saturating service counters (stat_clr / stat_served).
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_shared_sched
  import dtc_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int W           = DTC_W,
  parameter int OW          = DTC_OW,
  parameter int EVAL_CYCLES = 1,
  parameter int IDW         = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_data,
  output logic [W-1:0]             cls_inp,
  input  logic [OW-1:0]            cls_outp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OW-1:0]            rsp_data,
  output logic [IDW-1:0]           rsp_id,
`ifdef DTC_SCHED_STATS_EN
  input  logic                     stat_clr,
  output logic [N_REQ*STAT_W-1:0]  stat_served,
`endif
  output logic                     busy
);

  // Counter holds EVAL_CYCLES-1 down to 0; 4 bits covers the 1..15 range
  localparam int CW = 4;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   feat_q, feat_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [OW-1:0]  rsp_data_q, rsp_data_d;
  logic           busy_q, busy_d;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [W-1:0]     sel_feat;
  logic [IDW-1:0]   ptr_next;

  dtc_rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Arbiter only grants a valid requester, so a grant is the handshake
  assign req_ready = gnt;
  assign sel_feat  = req_data[int'(gnt_idx)*W +: W];
  assign ptr_next  = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Next-state logic for the IDLE -> EVAL -> RESP transaction sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    feat_d      = feat_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          feat_d  = sel_feat;
          id_d    = gnt_idx;
          ptr_d   = ptr_next;
          cnt_d   = CW'(EVAL_CYCLES - 1);
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          rsp_data_d  = cls_outp;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      feat_q      <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      feat_q      <= feat_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  // Feature register doubles as the classifier drive and is never cleared
  assign cls_inp   = feat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

`ifdef DTC_SCHED_STATS_EN
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_stat
    logic [STAT_W-1:0] served_q, served_d;

    // Clear wins over a same-cycle increment; count sticks at all-ones
    always_comb begin
      served_d = served_q;
      if (stat_clr) begin
        served_d = '0;
      end else if ((state_q == RESP) && rsp_ready && (id_q == IDW'(gi)) &&
                   (served_q != {STAT_W{1'b1}})) begin
        served_d = served_q + 1'b1;
      end
    end

    // Service counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) served_q <= '0;
      else        served_q <= served_d;
    end

    assign stat_served[gi*STAT_W +: STAT_W] = served_q;
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_dtc_shared_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtc_shared_sched
// Description : Directed self-checking bench for dtc_shared_sched. A second
//               instance with EVAL_CYCLES=4 exercises the multicycle sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtc_shared_sched;

  localparam int N   = 4;
  localparam int W   = 14;
  localparam int OW  = 14;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;

  // Instance with EVAL_CYCLES=1
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   cls_inp;
  logic [OW-1:0]  cls_outp;
  logic           rsp_valid, rsp_ready, busy;
  logic [OW-1:0]  rsp_data;
  logic [IDW-1:0] rsp_id;

  // Instance with EVAL_CYCLES=4; classifier output driven directly
  logic [N-1:0]   req_valid4, req_ready4;
  logic [N*W-1:0] req_data4;
  logic [W-1:0]   cls_inp4;
  logic [OW-1:0]  cls_outp4;
  logic           rsp_valid4, rsp_ready4, busy4;
  logic [OW-1:0]  rsp_data4;
  logic [IDW-1:0] rsp_id4;

`ifdef DTC_SCHED_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_served, stat_served4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in for the decision-tree classifier
  function automatic logic [OW-1:0] cls_model(input logic [W-1:0] x);
    return {x[6:0], x[13:7]} ^ 14'h2A5C;
  endfunction

  assign cls_outp = cls_model(cls_inp);

  dtc_shared_sched #(.N_REQ(N), .W(W), .OW(OW), .EVAL_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .cls_inp(cls_inp), .cls_outp(cls_outp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef DTC_SCHED_STATS_EN
    .stat_clr(stat_clr), .stat_served(stat_served),
`endif
    .busy(busy)
  );

  dtc_shared_sched #(.N_REQ(N), .W(W), .OW(OW), .EVAL_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_data(req_data4),
    .cls_inp(cls_inp4), .cls_outp(cls_outp4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_id(rsp_id4),
`ifdef DTC_SCHED_STATS_EN
    .stat_clr(stat_clr), .stat_served(stat_served4),
`endif
    .busy(busy4)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_valid4 = '0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
`ifdef DTC_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_valid4 = '0; req_data = '0; req_data4 = '0;
    rsp_ready = 1'b0; rsp_ready4 = 1'b0; cls_outp4 = '0;
`ifdef DTC_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_data !== 14'h0) begin n_fail++; $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (cls_inp !== 14'h0) begin n_fail++; $display("FAIL rst_cls_inp: got %h expected 0", cls_inp); end
    n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    n_checks++; if (rsp_valid4 !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid4: got %b expected 0", rsp_valid4); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    req_data[0 +: W] = 14'h0403;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_ready: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++; if (cls_inp !== 14'h0403) begin n_fail++; $display("FAIL basic_cls_inp: got %h expected 0403", cls_inp); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_eval: got %b expected 1", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL basic_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (rsp_data !== cls_model(14'h0403)) begin n_fail++; $display("FAIL basic_rsp_data: got %h expected %h", rsp_data, cls_model(14'h0403)); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_clear: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
    n_checks++; if (cls_inp !== 14'h0403) begin n_fail++; $display("FAIL basic_cls_hold: got %h expected 0403", cls_inp); end
  endtask

  task automatic test_rotation();
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(14'h0111 * (i + 1));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      exp = t % N;
      n_checks++; if (req_ready !== 4'(1 << exp)) begin n_fail++; $display("FAIL rot_grant[%0d]: got %b expected %b", t, req_ready, 4'(1 << exp)); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rot_busy_accept[%0d]: got %b expected 0", t, busy); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rot_busy_eval[%0d]: got %b expected 1", t, busy); end
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rot_ready_eval[%0d]: got %b expected 0000", t, req_ready); end
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid[%0d]: got %b expected 1", t, rsp_valid); end
      n_checks++; if (rsp_id !== IDW'(exp)) begin n_fail++; $display("FAIL rot_id[%0d]: got %0d expected %0d", t, rsp_id, exp); end
      n_checks++; if (rsp_data !== cls_model(W'(14'h0111 * (exp + 1)))) begin n_fail++; $display("FAIL rot_data[%0d]: got %h expected %h", t, rsp_data, cls_model(W'(14'h0111 * (exp + 1)))); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data[2*W +: W] = 14'h1ABC;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'hF;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", rsp_valid); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, rsp_valid); end
      n_checks++; if (rsp_data !== cls_model(14'h1ABC)) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", c, rsp_data, cls_model(14'h1ABC)); end
      n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_hold_id[%0d]: got %0d expected 2", c, rsp_id); end
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0000", c, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 1000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_eval4();
    do_reset();
    req_data4[0 +: W] = 14'h0777;
    cls_outp4 = 14'h0AAA;
    req_valid4 = 4'b0001;
    rsp_ready4 = 1'b0;
    #1;
    n_checks++; if (req_ready4 !== 4'b0001) begin n_fail++; $display("FAIL ev4_grant: got %b expected 0001", req_ready4); end
    @(negedge clk);
    req_valid4 = '0;
    for (int e = 1; e <= 4; e++) begin
      if (e > 1) @(negedge clk);
      if (e == 4) cls_outp4 = 14'h1234;
      #1;
      n_checks++; if (cls_inp4 !== 14'h0777) begin n_fail++; $display("FAIL ev4_cls_inp[%0d]: got %h expected 0777", e, cls_inp4); end
      n_checks++; if (rsp_valid4 !== 1'b0) begin n_fail++; $display("FAIL ev4_early_valid[%0d]: got %b expected 0", e, rsp_valid4); end
      n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL ev4_busy[%0d]: got %b expected 1", e, busy4); end
    end
    @(negedge clk);
    n_checks++; if (rsp_valid4 !== 1'b1) begin n_fail++; $display("FAIL ev4_valid: got %b expected 1", rsp_valid4); end
    n_checks++; if (rsp_data4 !== 14'h1234) begin n_fail++; $display("FAIL ev4_data: got %h expected 1234", rsp_data4); end
    n_checks++; if (rsp_id4 !== 2'd0) begin n_fail++; $display("FAIL ev4_id: got %0d expected 0", rsp_id4); end
    rsp_ready4 = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid4 !== 1'b0) begin n_fail++; $display("FAIL ev4_clear: got %b expected 0", rsp_valid4); end
    rsp_ready4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[2*W +: W] = 14'h2468;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_grant: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_eval: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
    n_checks++; if (cls_inp !== 14'h0) begin n_fail++; $display("FAIL rm_cls_inp: got %h expected 0", cls_inp); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rm_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (rsp_data !== 14'h0) begin n_fail++; $display("FAIL rm_rsp_data: got %h expected 0", rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp[%0d]: got %b expected 0", c, rsp_valid); end
    end
    req_valid = 4'hF;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_ptr_zero: got %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

`ifdef DTC_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    req_data[1*W +: W] = 14'h0055;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    repeat (9) @(negedge clk);
    n_checks++; if (stat_served[16 +: 16] !== 16'd3) begin n_fail++; $display("FAIL st_count1: got %0d expected 3", stat_served[16 +: 16]); end
    n_checks++; if (stat_served[0 +: 16] !== 16'd0) begin n_fail++; $display("FAIL st_count0: got %0d expected 0", stat_served[0 +: 16]); end
    n_checks++; if (stat_served4 !== '0) begin n_fail++; $display("FAIL st_other_inst: got %h expected 0", stat_served4); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL st_lone_id: got %0d expected 1", rsp_id); end
    stat_clr = 1'b1;
    req_valid = '0;
    @(negedge clk);
    stat_clr = 1'b0;
    n_checks++; if (stat_served[16 +: 16] !== 16'd0) begin n_fail++; $display("FAIL st_clr_prio: got %0d expected 0", stat_served[16 +: 16]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_backpressure();
    test_eval4();
    test_reset_mid();
`ifdef DTC_SCHED_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
